// File: rtl/ram_arbiter_if.sv
// Request/response bundle for one picorv32-style memory port; on the RAM side wstrb carries the byte write enables.
// master drives the request fields, slave returns ready/rdata.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic [31:0]       rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin sharing of one single-port RAM between two masters; 4 cycles per access (grant, 2x BUSY, DONE).
// Losing master simply holds valid until granted; a watchdog completes accesses whose RAM ready never comes.
module ram_arbiter #(
  parameter int          ADDR_W   = 8,
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  ram_arbiter_if.master s,
  output logic          owner,
  output logic          timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              terr_q, terr_d;
  logic [31:0]       rd0_q, rd0_d;
  logic [31:0]       rd1_q, rd1_d;
  logic              grant_m1;
  logic [31:0]       cap;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wd_d     = wd_q;
    terr_d   = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    grant_m1 = 1'b0;
    cap      = '0;

    case (state_q)
      S_IDLE: begin
        // On a tie the master that was not served last wins.
        grant_m1 = m1.valid && (!m0.valid || !last_q);
        if (m0.valid || m1.valid) begin
          owner_d = grant_m1;
          last_d  = grant_m1;
          addr_d  = grant_m1 ? m1.addr  : m0.addr;
          wdata_d = grant_m1 ? m1.wdata : m0.wdata;
          wstrb_d = grant_m1 ? m1.wstrb : m0.wstrb;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        wd_d = wd_q + WD_W'(1);
        if (s.ready || (wd_d == WD_W'(TIMEOUT))) begin
          cap    = s.ready ? s.rdata : ERR_DATA;
          terr_d = !s.ready;
          if (owner_q) begin
            rd1_d = cap;
          end else begin
            rd0_d = cap;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        wd_d    = '0;
        state_d = S_IDLE;
      end

      default: begin
        wd_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // Watchdog is zero only in the first BUSY cycle, so it doubles as the single-shot write qualifier.
  assign s.valid  = (state_q == S_BUSY);
  assign s.addr   = addr_q;
  assign s.wdata  = wdata_q;
  assign s.wstrb  = ((state_q == S_BUSY) && (wd_q == '0)) ? wstrb_q : 4'h0;

  assign m0.ready = (state_q == S_DONE) && !owner_q;
  assign m1.ready = (state_q == S_DONE) &&  owner_q;
  assign m0.rdata = rd0_q;
  assign m1.rdata = rd1_q;

  assign owner       = owner_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master, round-robin arbiter that shares one single-port 32-bit RAM between two picorv32-style memory masters, e.g. the CPU data port and a DMA/debug port.
- The RAM has a one-cycle read latency: ready is valid delayed one cycle, and it writes whenever wen is nonzero.
- The arbiter serialises accesses and issues each write strobe exactly once.
- A watchdog completes any access whose slave ready never arrives.

Parameters:
- ADDR_W, 8: word-address width; log2 of the RAM word count.
- TIMEOUT, 15: maximum BUSY cycles to wait for s_ready; must be ≥ 2.
- ERR_DATA, 32'hDEADBEEF: rdata returned on timeout.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_ready  out  1  master 0 completion pulse
- m0_addr  in  ADDR_W  master 0 word address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_rdata  out  32  master 0 read data; valid with m0_ready
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: identical set for master 1
- s_valid  out  1  RAM request
- s_ready  in  1  RAM completion
- s_addr  out  ADDR_W  RAM address
- s_wdata  out  32  RAM write data
- s_wen  out  4  RAM byte write enables
- s_rdata  in  32  RAM read data
- owner  out  1  index of the master currently granted; meaningful in BUSY/DONE
- timeout_err  out  1  one-cycle pulse when an access times out

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - FSM = IDLE; all outputs 0.
  - Internal last-served pointer = 1, so m0 wins the first tie.
  - Watchdog count = 0; captured address, data, strobes and rdata = 0.
- Reset asserted mid-transaction: immediate return to IDLE. No master ready is generated and s_wen drops at once. The aborted request is re-served after release if the master still holds valid.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If only one valid is high, grant that master.
  - If both are high, grant the master that is not the last-served one.
  - On grant: register owner, the owner's addr/wdata/wstrb, and the last-served pointer. Next state BUSY.
- BUSY:
  - s_valid = 1. s_addr and s_wdata come from the registers captured at grant.
  - s_wen = captured wstrb in the first BUSY cycle only; 0 in every later cycle.
  - Watchdog increments every BUSY cycle.
  - If s_ready = 1: capture s_rdata, then go to DONE.
  - Else if the watchdog has reached TIMEOUT: load ERR_DATA as rdata, set timeout_err for the DONE cycle, then go to DONE.
  - s_ready takes precedence over timeout in the same cycle.
- DONE:
  - s_valid = 0, s_wen = 0.
  - The owner's mX_ready = 1 for exactly one cycle, and its mX_rdata = captured value. The other master's ready = 0 and its rdata holds its previous value.
  - Watchdog clears. Next state IDLE, unconditionally, so there are no back-to-back grants without an IDLE cycle.
- s_ready is ignored outside BUSY; a stale ready from the RAM in DONE or IDLE has no effect.
- Master inputs are ignored outside IDLE.
  - A request arriving during another master's transaction waits and is never dropped.
  - Masters must deassert valid in the cycle after ready.
- Latency with the single-cycle RAM:
  - valid seen in IDLE at cycle N → s_valid at N+1 → s_ready at N+2 → mX_ready at N+3.
  - 4 cycles per access; fairness is strictly alternating under continuous contention.
- Reads with wstrb = 0 never assert s_wen.
- owner remains stable from grant through DONE.

Test Plan:
1. m0 write addr 0x10, wdata 0xA5A5A5A5, wstrb 0xF, with the RAM model. Required: s_valid at N+1; s_wen=0xF only at N+1; m0_ready a single pulse at N+3. A following read of 0x10 returns 0xA5A5A5A5.
2. Byte write: word 0x20 preloaded 0xFFFFFFFF; m1 writes wdata 0x00003C00, wstrb 4'b0010. Required: readback 0xFFFF3CFF.
3. Both valids held high from reset release for 6 transactions. Required: owner sequence 0,1,0,1,0,1; each ready is 4 cycles apart in time; no double grant.
4. m1 asserts valid while an m0 access is in BUSY. Required: m1 is served immediately after m0's DONE→IDLE and completes with correct data; m0's data is unaffected.
5. s_ready tied 0, m1 read. Required:
   - m1_ready after 15 BUSY cycles with m1_rdata = 0xDEADBEEF.
   - timeout_err high exactly in that DONE cycle.
   - A following normal access completes correctly.
6. reset asserted in the first BUSY cycle of an m0 write. Required: all outputs 0 asynchronously and no m0_ready. After release with m0 still valid, the write reissues once and completes, and the RAM holds the correct word.
